// File: rtl/fetch_predictor.sv
// rtl/fetch_predictor.sv - fetch PC generator with a direct-mapped BTB and 2-bit counters
module fetch_predictor #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_ex,
    input  logic [31:0] redirect_ex_target,
    input  logic        redirect_id,
    input  logic [31:0] redirect_id_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] fetch_pc,
    output logic        fetch_valid,
    output logic [31:0] predicted_pc,
    output logic        prediction_valid
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0]            fetch_pc_q, fetch_pc_d;
    logic                   fetch_valid_q, fetch_valid_d;
    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [1:0]             cnt_q [BTB_ENTRIES];
    logic [1:0]             cnt_d [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_d [BTB_ENTRIES];
    logic [31:0]            tgt_q [BTB_ENTRIES];
    logic [31:0]            tgt_d [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx, up_idx;
    logic [TAG_W-1:0] rd_tag, up_tag;
    logic             rd_hit, up_hit;
    logic             unused_upd_pc_lsbs;

    assign unused_upd_pc_lsbs = ^upd_pc[1:0];

    assign rd_idx = fetch_pc_q[IDX_W+1:2];
    assign rd_tag = fetch_pc_q[31:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];

    // Lookup reads the registered arrays, so a same-cycle update is seen only next cycle.
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign fetch_pc         = fetch_pc_q;
    assign fetch_valid      = fetch_valid_q;
    assign prediction_valid = fetch_valid_q && rd_hit && cnt_q[rd_idx][1];
    assign predicted_pc     = prediction_valid ? tgt_q[rd_idx] : fetch_pc_q + 32'd4;

    always_comb begin
        fetch_valid_d = 1'b1;
        fetch_pc_d    = fetch_pc_q;
        if (fetch_valid_q) begin
            if (redirect_ex)
                fetch_pc_d = redirect_ex_target;
            else if (redirect_id)
                fetch_pc_d = redirect_id_target;
            else if (!stall)
                fetch_pc_d = predicted_pc;
        end
    end

    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (cnt_q[up_idx] != 2'b11)
                        cnt_d[up_idx] = cnt_q[up_idx] + 2'b01;
                    tgt_d[up_idx] = upd_target;
                end else if (cnt_q[up_idx] != 2'b00) begin
                    cnt_d[up_idx] = cnt_q[up_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = upd_target;
                cnt_d[up_idx]   = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            fetch_valid_q <= 1'b0;
            valid_q       <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++)
                cnt_q[i] <= 2'b00;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            valid_q       <= valid_d;
            cnt_q         <= cnt_d;
        end
    end

    // Tag/target payload is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tag_q <= tag_d;
            tgt_q <= tgt_d;
        end
    end
endmodule

// File: tb/tb_fetch_predictor.sv
// tb/tb_fetch_predictor.sv - directed self-checking bench for fetch_predictor
module tb_fetch_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_ex;
    logic [31:0] redirect_ex_target;
    logic        redirect_id;
    logic [31:0] redirect_id_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic [31:0] predicted_pc;
    logic        prediction_valid;

    int checks = 0;
    int errors = 0;

    fetch_predictor #(.BTB_ENTRIES(16), .RESET_PC(32'h8000_0000)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall              (stall),
        .redirect_ex        (redirect_ex),
        .redirect_ex_target (redirect_ex_target),
        .redirect_id        (redirect_id),
        .redirect_id_target (redirect_id_target),
        .upd_valid          (upd_valid),
        .upd_pc             (upd_pc),
        .upd_taken          (upd_taken),
        .upd_target         (upd_target),
        .fetch_pc           (fetch_pc),
        .fetch_valid        (fetch_valid),
        .predicted_pc       (predicted_pc),
        .prediction_valid   (prediction_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall       = 1'b0;
        redirect_ex = 1'b0;
        redirect_id = 1'b0;
        upd_valid   = 1'b0;
        upd_taken   = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
    endtask

    task automatic go_ex(input logic [31:0] tgt);
        redirect_ex        = 1'b1;
        redirect_ex_target = tgt;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        redirect_ex_target = '0;
        redirect_id_target = '0;
        upd_pc = '0;
        upd_target = '0;
        repeat (2) @(negedge clk);
        check("rst_pc", fetch_pc, 32'h8000_0000);
        check("rst_fv", {31'b0, fetch_valid}, 32'd0);
        check("rst_pv", {31'b0, prediction_valid}, 32'd0);
        check("rst_pred", predicted_pc, 32'h8000_0004);

        rst_n = 1'b1;
        step();
        check("first_pc", fetch_pc, 32'h8000_0000);
        check("first_fv", {31'b0, fetch_valid}, 32'd1);
        step();
        check("seq_04", fetch_pc, 32'h8000_0004);
        step();
        check("seq_08", fetch_pc, 32'h8000_0008);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", fetch_pc, 32'h8000_0008);
        end
        stall = 1'b0;
        step();
        check("stall_rel", fetch_pc, 32'h8000_000C);

        update(32'h8000_0010, 1'b1, 32'h8000_0100);
        step();
        idle_inputs();
        check("alloc_pc", fetch_pc, 32'h8000_0010);
        check("alloc_pv", {31'b0, prediction_valid}, 32'd1);
        check("alloc_pred", predicted_pc, 32'h8000_0100);
        step();
        check("taken_pc", fetch_pc, 32'h8000_0100);

        update(32'h8000_0010, 1'b0, 32'h0);
        step();
        update(32'h8000_0010, 1'b0, 32'h0);
        go_ex(32'h8000_0010);
        step();
        idle_inputs();
        check("nt2_pc", fetch_pc, 32'h8000_0010);
        check("nt2_pv", {31'b0, prediction_valid}, 32'd0);
        check("nt2_pred", predicted_pc, 32'h8000_0014);

        update(32'h8000_0010, 1'b1, 32'h8000_0180);
        redirect_id = 1'b1;
        redirect_id_target = 32'h8000_0010;
        step();
        idle_inputs();
        check("cnt01_pv", {31'b0, prediction_valid}, 32'd0);
        check("cnt01_pred", predicted_pc, 32'h8000_0014);

        update(32'h8000_0010, 1'b1, 32'h8000_0180);
        stall = 1'b1;
        #1;
        check("rbw_pv_before", {31'b0, prediction_valid}, 32'd0);
        step();
        idle_inputs();
        check("rbw_pc", fetch_pc, 32'h8000_0010);
        check("rbw_pv_after", {31'b0, prediction_valid}, 32'd1);
        check("rbw_tgt", predicted_pc, 32'h8000_0180);

        stall = 1'b1;
        go_ex(32'h8000_0200);
        redirect_id = 1'b1;
        redirect_id_target = 32'h8000_0300;
        step();
        check("ex_over_id", fetch_pc, 32'h8000_0200);
        redirect_ex = 1'b0;
        step();
        idle_inputs();
        check("id_over_stall", fetch_pc, 32'h8000_0300);

        update(32'h8000_0050, 1'b1, 32'h8000_0500);
        go_ex(32'h8000_0010);
        step();
        idle_inputs();
        check("alias_pc", fetch_pc, 32'h8000_0010);
        check("alias_pv", {31'b0, prediction_valid}, 32'd0);
        check("alias_pred", predicted_pc, 32'h8000_0014);

        go_ex(32'hFFFF_FFFC);
        step();
        idle_inputs();
        check("wrap_pc", fetch_pc, 32'hFFFF_FFFC);
        check("wrap_pred", predicted_pc, 32'h0000_0000);
        step();
        check("wrap_next", fetch_pc, 32'h0000_0000);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", fetch_pc, 32'h8000_0000);
        check("async_rst_fv", {31'b0, fetch_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        go_ex(32'h8000_0050);
        step();
        idle_inputs();
        check("post_rst_pc", fetch_pc, 32'h8000_0050);
        check("post_rst_pv", {31'b0, prediction_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
